// File: rtl/t07_scroll_sprite_gen.sv
// t07_scroll_sprite_gen: side-scrolling sprite pixel generator.
// It draws a floor band, a jumping dino and NUM_CACTUS scrolling cacti.
// The three pixel outputs are registered one cycle after x/y.
// Optional feature macro: T07_COLLISION_EN.
// When it is defined, collide is a sticky flag that freezes all motion.
// When it is undefined, collide is tied low and no freeze logic is built.
//
// state  | meaning
// GROUND | dino on floor, jh = 0, waits for jump on frame_tick
// RISE   | jh grows by JUMP_STEP per frame_tick up to JUMP_H
// FALL   | jh shrinks by JUMP_STEP per frame_tick back to 0
module t07_scroll_sprite_gen #(
    parameter int NUM_CACTUS = 2,
    parameter int FLOOR_Y    = 150,
    parameter int DINO_X     = 20,
    parameter int DINO_W     = 20,
    parameter int DINO_H     = 40,
    parameter int CACTUS_W   = 20,
    parameter int CACTUS_H1  = 20,
    parameter int CACTUS_H2  = 40,
    parameter int CACTUS_X0  = 250,
    parameter int CACTUS_GAP = 60,
    parameter int X_MAX      = 319,
    parameter int SPEED      = 2,
    parameter int JUMP_H     = 60,
    parameter int JUMP_STEP  = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       jump,
    output logic       r_floor,
    output logic       r_dino,
    output logic       r_cactus,
    output logic       collide
);

    localparam logic [1:0] GROUND = 2'd0;
    localparam logic [1:0] RISE   = 2'd1;
    localparam logic [1:0] FALL   = 2'd2;

    // Bound arithmetic is done in 10 bits so no sum can wrap.
    localparam logic [9:0] Y_LO    = 10'(FLOOR_Y + 1);
    localparam logic [9:0] Y_HI_EV = 10'(FLOOR_Y + 1 + CACTUS_H1);
    localparam logic [9:0] Y_HI_OD = 10'(FLOOR_Y + 1 + CACTUS_H2);
    localparam logic [9:0] DX_LO   = 10'(DINO_X);
    localparam logic [9:0] DX_HI   = 10'(DINO_X + DINO_W);

    logic [1:0] state_q, state_d;
    logic [7:0] jh_q, jh_d;
    logic [8:0] cx_q [NUM_CACTUS];
    logic [8:0] cx_d [NUM_CACTUS];
    logic [8:0] jh_sum;
    logic [9:0] x_w, y_w, dy_lo, dy_hi;
    logic       floor_c, dino_c, cactus_c;
    logic       upd;

    assign x_w   = {1'b0, x};
    assign y_w   = {2'b00, y};
    assign dy_lo = Y_LO + {2'b00, jh_q};
    assign dy_hi = dy_lo + 10'(DINO_H);

    // Pixel coverage from the current (pre-update) positions.
    always_comb begin
        floor_c  = (y_w <= 10'(FLOOR_Y));
        dino_c   = (x_w >= DX_LO) && (x_w <= DX_HI) && (y_w >= dy_lo) && (y_w <= dy_hi);
        cactus_c = 1'b0;
        for (int i = 0; i < NUM_CACTUS; i++) begin
            if ((x_w >= {1'b0, cx_q[i]}) &&
                (x_w <= ({1'b0, cx_q[i]} + 10'(CACTUS_W))) &&
                (y_w >= Y_LO) &&
                (y_w <= (((i % 2) == 0) ? Y_HI_EV : Y_HI_OD))) begin
                cactus_c = 1'b1;
            end
        end
    end

`ifdef T07_COLLISION_EN
    logic collide_q;

    // Sticky overlap flag; once set it freezes scrolling and jumping.
    always_ff @(posedge clk) begin
        if (!nrst) collide_q <= 1'b0;
        else       collide_q <= collide_q | (dino_c & cactus_c);
    end

    assign upd     = frame_tick & run & ~collide_q;
    assign collide = collide_q;
`else
    assign upd     = frame_tick & run;
    assign collide = 1'b0;
`endif

    assign jh_sum = {1'b0, jh_q} + 9'(JUMP_STEP);

    // Per-frame scroll of each cactus and jump FSM step.
    always_comb begin
        state_d = state_q;
        jh_d    = jh_q;
        for (int i = 0; i < NUM_CACTUS; i++) cx_d[i] = cx_q[i];
        if (upd) begin
            for (int i = 0; i < NUM_CACTUS; i++) begin
                if (cx_q[i] < 9'(SPEED)) cx_d[i] = 9'(X_MAX);
                else                     cx_d[i] = cx_q[i] - 9'(SPEED);
            end
            case (state_q)
                GROUND: begin
                    if (jump) state_d = RISE;
                end
                RISE: begin
                    if (jh_sum >= 9'(JUMP_H)) begin
                        jh_d    = 8'(JUMP_H);
                        state_d = FALL;
                    end else begin
                        jh_d = jh_sum[7:0];
                    end
                end
                FALL: begin
                    if (jh_q <= 8'(JUMP_STEP)) begin
                        jh_d    = 8'd0;
                        state_d = GROUND;
                    end else begin
                        jh_d = jh_q - 8'(JUMP_STEP);
                    end
                end
                default: begin
                    jh_d    = 8'd0;
                    state_d = GROUND;
                end
            endcase
        end
    end

    // State, positions and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= GROUND;
            jh_q     <= 8'd0;
            r_floor  <= 1'b0;
            r_dino   <= 1'b0;
            r_cactus <= 1'b0;
            for (int i = 0; i < NUM_CACTUS; i++) cx_q[i] <= 9'(CACTUS_X0 - i * CACTUS_GAP);
        end else begin
            state_q  <= state_d;
            jh_q     <= jh_d;
            r_floor  <= floor_c;
            r_dino   <= dino_c;
            r_cactus <= cactus_c;
            for (int i = 0; i < NUM_CACTUS; i++) cx_q[i] <= cx_d[i];
        end
    end

endmodule

// File: tb/tb_t07_scroll_sprite_gen.sv
// Self-checking bench for t07_scroll_sprite_gen (default parameters).
module tb_t07_scroll_sprite_gen;

    localparam int FLOOR_Y = 150, DINO_X = 20, DINO_W = 20, DINO_H = 40;
    localparam int CW = 20, H1 = 20, H2 = 40, X0 = 250, GAP = 60;
    localparam int X_MAX = 319, SPEED = 2, JUMP_H = 60, JUMP_STEP = 4;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [8:0] x = '0;
    logic [7:0] y = '0;
    logic       frame_tick = 1'b0, run = 1'b0, jump = 1'b0;
    logic       r_floor, r_dino, r_cactus, collide;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model: positions, jump height, phase (0 ground, 1 up, 2 down), sticky flag
    int m_cx [2];
    int m_jh, m_ph;
    bit m_col;
    bit e_floor, e_dino, e_cactus, e_col;

    always #5 clk = ~clk;

    t07_scroll_sprite_gen dut (
        .clk(clk), .nrst(nrst), .x(x), .y(y), .frame_tick(frame_tick), .run(run),
        .jump(jump), .r_floor(r_floor), .r_dino(r_dino), .r_cactus(r_cactus), .collide(collide)
    );

    function automatic void model_pix(input int px, input int py, output bit f, output bit d, output bit c);
        int h;
        f = (py <= FLOOR_Y);
        d = (px >= DINO_X) && (px <= DINO_X + DINO_W) &&
            (py >= FLOOR_Y + 1 + m_jh) && (py <= FLOOR_Y + 1 + m_jh + DINO_H);
        c = 1'b0;
        for (int i = 0; i < 2; i++) begin
            h = (i % 2 == 0) ? H1 : H2;
            if (px >= m_cx[i] && px <= m_cx[i] + CW && py >= FLOOR_Y + 1 && py <= FLOOR_Y + 1 + h) c = 1'b1;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m_cx[i] = X0 - i * GAP;
        m_jh = 0; m_ph = 0; m_col = 1'b0;
        e_floor = 0; e_dino = 0; e_cactus = 0; e_col = 0;
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        frame_tick = 1'($urandom_range(0, 1));
        run = 1'b1; jump = 1'b1;
        x = 9'd30; y = 8'd160;
        @(posedge clk); #1;
        nrst = 1'b1;
        model_reset();
    endtask

    // Drive one cycle, then advance the model with the frame rules.
    task automatic step(input int px, input int py, input bit tk, input bit rn, input bit jp);
        bit f, d, c, frz;
        x = 9'(px); y = 8'(py); frame_tick = tk; run = rn; jump = jp;
        model_pix(px, py, f, d, c);
        frz = 1'b0;
`ifdef T07_COLLISION_EN
        frz = m_col;
`endif
        @(posedge clk); #1;
        if (tk && rn && !frz) begin
            for (int i = 0; i < 2; i++) m_cx[i] = (m_cx[i] < SPEED) ? X_MAX : m_cx[i] - SPEED;
            if (m_ph == 0) begin
                if (jp) m_ph = 1;
            end else if (m_ph == 1) begin
                m_jh += JUMP_STEP;
                if (m_jh >= JUMP_H) begin m_jh = JUMP_H; m_ph = 2; end
            end else begin
                if (m_jh <= JUMP_STEP) begin m_jh = 0; m_ph = 0; end
                else m_jh -= JUMP_STEP;
            end
        end
`ifdef T07_COLLISION_EN
        if (d && c) m_col = 1'b1;
`endif
        e_floor = f; e_dino = d; e_cactus = c; e_col = m_col;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({r_floor, r_dino, r_cactus, collide} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b want=0000", {r_floor, r_dino, r_cactus, collide});
        end
        tests_run++;
        if (int'(dut.cx_q[0]) !== m_cx[0] || int'(dut.cx_q[1]) !== m_cx[1] || int'(dut.jh_q) !== 0) begin
            tests_failed++;
            $display("FAIL reset_state got cx=%0d/%0d jh=%0d want cx=%0d/%0d jh=0",
                     dut.cx_q[0], dut.cx_q[1], dut.jh_q, m_cx[0], m_cx[1]);
        end
        step(100, 100, 0, 1, 0);
        tests_run++;
        if ({r_floor, r_dino, r_cactus} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_first_pixel got=%b want=100", {r_floor, r_dino, r_cactus});
        end
    endtask

    task automatic test_pixels();
        int px [12] = '{250, 200, 200, 270, 271, 270, 40, 41, 40, 30, 100, 210};
        int py [12] = '{160, 185, 192, 171, 160, 172, 191, 191, 150, 150, 151, 191};
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            step(px[k], py[k], 0, 1, 0);
            tests_run++;
            if ({r_floor, r_dino, r_cactus} !== {e_floor, e_dino, e_cactus}) begin
                tests_failed++;
                $display("FAIL pixel(%0d,%0d) got fdc=%b want=%b", px[k], py[k],
                         {r_floor, r_dino, r_cactus}, {e_floor, e_dino, e_cactus});
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 0; k < 290; k++) begin
            step(0, 0, 1, 1, 0);
            if (m_cx[0] <= 2 || m_cx[0] == X_MAX || k % 37 == 0) begin
                tests_run++;
                if (int'(dut.cx_q[0]) !== m_cx[0] || int'(dut.cx_q[1]) !== m_cx[1]) begin
                    tests_failed++;
                    $display("FAIL wrap_cx tick=%0d got=%0d/%0d want=%0d/%0d", k,
                             dut.cx_q[0], dut.cx_q[1], m_cx[0], m_cx[1]);
                end
            end
        end
    endtask

    task automatic test_jump();
        apply_reset();
        step(0, 0, 1, 1, 1);
        for (int k = 0; k < 31; k++) begin
            step(0, 0, 0, 1, 1);
            step(0, 0, 1, 1, (k < 15));
            tests_run++;
            if (int'(dut.jh_q) !== m_jh || int'(dut.cx_q[1]) !== m_cx[1]) begin
                tests_failed++;
                $display("FAIL jump_jh tick=%0d got jh=%0d cx1=%0d want jh=%0d cx1=%0d", k,
                         dut.jh_q, dut.cx_q[1], m_jh, m_cx[1]);
            end
        end
        step(DINO_X, FLOOR_Y + 1 + DINO_H, 0, 1, 0);
        tests_run++;
        if (r_dino !== 1'b1 || m_jh !== 0) begin
            tests_failed++;
            $display("FAIL jump_landed got r_dino=%b model_jh=%0d want 1/0", r_dino, m_jh);
        end
    endtask

    task automatic test_run_hold();
        int cx1;
        apply_reset();
        step(0, 0, 1, 1, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, 0);
        cx1 = m_cx[1];
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 0, 1);
            tests_run++;
            if (int'(dut.jh_q) !== m_jh || int'(dut.cx_q[1]) !== cx1) begin
                tests_failed++;
                $display("FAIL run_hold got jh=%0d cx1=%0d want jh=%0d cx1=%0d",
                         dut.jh_q, dut.cx_q[1], m_jh, cx1);
            end
        end
        step(0, 0, 1, 1, 0);
        tests_run++;
        if (int'(dut.jh_q) !== m_jh) begin
            tests_failed++;
            $display("FAIL run_resume got jh=%0d want %0d", dut.jh_q, m_jh);
        end
        apply_reset();
        tests_run++;
        if (int'(dut.jh_q) !== 0 || int'(dut.cx_q[0]) !== m_cx[0] || int'(dut.cx_q[1]) !== m_cx[1]) begin
            tests_failed++;
            $display("FAIL reset_midjump got jh=%0d cx=%0d/%0d want 0 %0d/%0d",
                     dut.jh_q, dut.cx_q[0], dut.cx_q[1], m_cx[0], m_cx[1]);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        for (int k = 0; k < 100; k++) begin
            step(30, 160, 1, 1, 0);
            tests_run++;
            if (collide !== e_col || int'(dut.cx_q[0]) !== m_cx[0] || int'(dut.cx_q[1]) !== m_cx[1]) begin
                tests_failed++;
                $display("FAIL collision tick=%0d got col=%b cx=%0d/%0d want col=%b cx=%0d/%0d", k,
                         collide, dut.cx_q[0], dut.cx_q[1], e_col, m_cx[0], m_cx[1]);
            end
        end
        apply_reset();
        tests_run++;
        if (collide !== 1'b0 || int'(dut.cx_q[0]) !== 250 || int'(dut.cx_q[1]) !== 190) begin
            tests_failed++;
            $display("FAIL collision_reset got col=%b cx=%0d/%0d want 0 250/190",
                     collide, dut.cx_q[0], dut.cx_q[1]);
        end
    endtask

    task automatic test_random();
        int px, py;
        apply_reset();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                px = $urandom_range(0, 340); py = $urandom_range(0, 255);
            end else begin
                px = $urandom_range(0, 70) + (($urandom_range(0, 1) == 0) ? 0 : 180);
                py = $urandom_range(140, 255);
            end
            step(px, py, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
            tests_run++;
            if ({r_floor, r_dino, r_cactus, collide} !== {e_floor, e_dino, e_cactus, e_col}) begin
                tests_failed++;
                $display("FAIL random_pix cyc=%0d (%0d,%0d) got fdcx=%b want=%b", k, px, py,
                         {r_floor, r_dino, r_cactus, collide}, {e_floor, e_dino, e_cactus, e_col});
            end
            if (k % 50 == 49) begin
                tests_run++;
                if (int'(dut.jh_q) !== m_jh || int'(dut.cx_q[0]) !== m_cx[0] || int'(dut.cx_q[1]) !== m_cx[1]) begin
                    tests_failed++;
                    $display("FAIL random_state cyc=%0d got jh=%0d cx=%0d/%0d want jh=%0d cx=%0d/%0d", k,
                             dut.jh_q, dut.cx_q[0], dut.cx_q[1], m_jh, m_cx[0], m_cx[1]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_pixels();
        test_wrap();
        test_jump();
        test_run_hold();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
